// File: rtl/amount_entry.sv
// Purpose: keypad amount entry; collects up to three BCD digits, converts to binary, offers it to the balance counter.
// Latency: valid rises on the 4th rising edge after the edge that samples push_enter (3 accumulate cycles + 1 range check).
// Backpressure: amount/valid are held in REQ until ack=1 is sampled; push_clear aborts from any state.
//
// Ports:
//   clk, rst (sync, active-low)     clock and reset
//   digit[3:0], push_digit          BCD digit and its append pulse
//   push_enter, push_clear          submit / discard pulses (clear > enter > digit)
//   ack                             balance counter took the amount (REQ only)
//   amount[7:0], valid              binary amount offer, held stable while valid
//   err                             sticky rejection flag, cleared by push_clear
//   bcd_out[11:0]                   {hunds,tens,ones} for the display scanner
//   busy                            high while converting or offering
module amount_entry #(
    parameter int MAX_AMOUNT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit,
    input  logic        push_digit,
    input  logic        push_enter,
    input  logic        push_clear,
    input  logic        ack,
    output logic [7:0]  amount,
    output logic        valid,
    output logic        err,
    output logic [11:0] bcd_out,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTRY = 3'd1;
    localparam logic [2:0] S_CONV  = 3'd2;
    localparam logic [2:0] S_REQ   = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [9:0] MAX_ACC = 10'(MAX_AMOUNT);

    logic [2:0]  state, state_n;
    logic [1:0]  cnt, cnt_n;
    logic [1:0]  step, step_n;
    logic [9:0]  acc, acc_n;
    logic [11:0] bcd_n;
    logic [7:0]  amount_n;
    logic        valid_n, err_n;
    logic [3:0]  conv_digit;

    // Digit consumed by the current accumulate step: hundreds first.
    always_comb begin
        conv_digit = bcd_out[3:0];
        case (step)
            2'd0:    conv_digit = bcd_out[11:8];
            2'd1:    conv_digit = bcd_out[7:4];
            default: conv_digit = bcd_out[3:0];
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        step_n   = step;
        acc_n    = acc;
        bcd_n    = bcd_out;
        amount_n = amount;
        valid_n  = valid;
        err_n    = err;

        if (push_clear) begin
            state_n  = S_IDLE;
            cnt_n    = 2'd0;
            step_n   = 2'd0;
            acc_n    = 10'd0;
            bcd_n    = 12'd0;
            amount_n = 8'd0;
            valid_n  = 1'b0;
            err_n    = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ENTRY: begin
                    if (push_enter) begin
                        // Enter wins over a simultaneous digit; in IDLE there is nothing to submit.
                        if (state == S_ENTRY) begin
                            state_n = S_CONV;
                            acc_n   = 10'd0;
                            step_n  = 2'd0;
                        end
                    end else if (push_digit) begin
                        if (digit > 4'd9) begin
                            err_n   = 1'b1;
                            state_n = S_ERR;
                        end else begin
                            state_n = S_ENTRY;
                            // A fourth digit is dropped so the display keeps the first three.
                            if (cnt != 2'd3) begin
                                bcd_n = {bcd_out[7:0], digit};
                                cnt_n = cnt + 2'd1;
                            end
                        end
                    end
                end
                S_CONV: begin
                    if (step != 2'd3) begin
                        acc_n  = 10'(acc * 10'd10) + {6'd0, conv_digit};
                        step_n = step + 2'd1;
                    end else if ((acc == 10'd0) || (acc > MAX_ACC)) begin
                        err_n   = 1'b1;
                        state_n = S_ERR;
                    end else begin
                        amount_n = acc[7:0];
                        valid_n  = 1'b1;
                        state_n  = S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        state_n  = S_IDLE;
                        valid_n  = 1'b0;
                        amount_n = 8'd0;
                        bcd_n    = 12'd0;
                        cnt_n    = 2'd0;
                    end
                end
                S_ERR: begin
                    // Hold err and the display until push_clear.
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 2'd0;
            step    <= 2'd0;
            acc     <= 10'd0;
            bcd_out <= 12'd0;
            amount  <= 8'd0;
            valid   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            step    <= step_n;
            acc     <= acc_n;
            bcd_out <= bcd_n;
            amount  <= amount_n;
            valid   <= valid_n;
            err     <= err_n;
            busy    <= (state_n == S_CONV) || (state_n == S_REQ);
        end
    end

endmodule

// File: tb/tb_amount_entry.sv
module tb_amount_entry;

    localparam int MAX = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  digit;
    logic        push_digit, push_enter, push_clear, ack;
    logic [7:0]  amount;
    logic        valid, err, busy;
    logic [11:0] bcd_out;

    int checks = 0;
    int failures = 0;

    // Reference model: digits accepted so far and the sticky error flag.
    int q[$];
    bit merr;

    amount_entry #(.MAX_AMOUNT(MAX)) dut (
        .clk(clk), .rst(rst), .digit(digit), .push_digit(push_digit),
        .push_enter(push_enter), .push_clear(push_clear), .ack(ack),
        .amount(amount), .valid(valid), .err(err), .bcd_out(bcd_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_val();
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    function automatic logic [11:0] model_bcd();
        int v = model_val();
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic press(input int d);
        digit = 4'(d);
        push_digit = 1'b1;
        tick();
        push_digit = 1'b0;
        if (!merr) begin
            if (d > 9) merr = 1'b1;
            else if (q.size() < 3) q.push_back(d);
        end
        check("digit_bcd", 32'(bcd_out), 32'(model_bcd()));
        check("digit_err", 32'(err), 32'(merr));
    endtask

    task automatic clear();
        push_clear = 1'b1;
        tick();
        push_clear = 1'b0;
        q.delete();
        merr = 1'b0;
        check("clear_err", 32'(err), 32'd0);
        check("clear_bcd", 32'(bcd_out), 32'd0);
        check("clear_busy", 32'(busy), 32'd0);
    endtask

    // Submit the current entry and follow it through to IDLE (ack) or a cleared error.
    task automatic enter_and_finish(input int hold);
        int v = model_val();
        bit ok = (v != 0) && (v <= MAX);
        logic [11:0] shown = model_bcd();
        push_enter = 1'b1;
        tick();
        push_enter = 1'b0;
        for (int e = 0; e < 3; e++) begin
            check("conv_busy", 32'(busy), 32'd1);
            check("conv_valid", 32'(valid), 32'd0);
            tick();
        end
        check("conv_busy", 32'(busy), 32'd1);
        check("conv_valid", 32'(valid), 32'd0);
        tick();
        if (ok) begin
            check("req_valid", 32'(valid), 32'd1);
            check("req_amount", 32'(amount), 32'(v));
            check("req_busy", 32'(busy), 32'd1);
            for (int h = 0; h < hold; h++) begin
                push_digit = 1'b1; digit = 4'd3;
                tick();
                push_digit = 1'b0;
                check("hold_valid", 32'(valid), 32'd1);
                check("hold_amount", 32'(amount), 32'(v));
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
            q.delete();
            check("ack_valid", 32'(valid), 32'd0);
            check("ack_amount", 32'(amount), 32'd0);
            check("ack_bcd", 32'(bcd_out), 32'd0);
            check("ack_busy", 32'(busy), 32'd0);
        end else begin
            merr = 1'b1;
            check("rej_err", 32'(err), 32'd1);
            check("rej_valid", 32'(valid), 32'd0);
            check("rej_busy", 32'(busy), 32'd0);
            push_enter = 1'b1;
            tick();
            push_enter = 1'b0;
            check("err_enter_err", 32'(err), 32'd1);
            check("err_enter_bcd", 32'(bcd_out), 32'(shown));
            clear();
        end
    endtask

    initial begin
        rst = 1'b0; digit = 4'd0; push_digit = 1'b0; push_enter = 1'b0;
        push_clear = 1'b0; ack = 1'b0; merr = 1'b0;
        tick(); tick();
        check("rst_amount", 32'(amount), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();

        // 1,2,8 -> 128 offered, then acked.
        press(1); press(2); press(8);
        check("bcd_128", 32'(bcd_out), 32'h128);
        enter_and_finish(2);

        // Upper boundary accepted; 256 rejected.
        press(2); press(5); press(5);
        enter_and_finish(0);
        press(2); press(5); press(6);
        enter_and_finish(0);

        // Fourth digit dropped, 753 rejected; all-zero entry rejected.
        press(7); press(5); press(3); press(9);
        check("bcd_753", 32'(bcd_out), 32'h753);
        enter_and_finish(0);
        press(0); press(0); press(0);
        enter_and_finish(0);

        // Non-BCD digit goes to ERR; enter there is ignored.
        press(4);
        press(10);
        check("bad_digit_err", 32'(err), 32'd1);
        check("bad_digit_bcd", 32'(bcd_out), 32'h004);
        push_enter = 1'b1; tick(); push_enter = 1'b0;
        check("err_enter_busy", 32'(busy), 32'd0);
        check("err_enter_hold", 32'(bcd_out), 32'h004);
        clear();

        // ack outside REQ is ignored.
        press(6);
        ack = 1'b1; tick(); ack = 1'b0;
        check("ack_ignored", 32'(bcd_out), 32'h006);

        // Clear beats a simultaneous digit; enter in IDLE keeps busy low.
        push_clear = 1'b1; push_digit = 1'b1; digit = 4'd3;
        tick();
        push_clear = 1'b0; push_digit = 1'b0;
        q.delete();
        check("clr_dig_bcd", 32'(bcd_out), 32'h000);
        push_enter = 1'b1; tick(); push_enter = 1'b0;
        check("idle_enter_busy", 32'(busy), 32'd0);
        check("idle_enter_valid", 32'(valid), 32'd0);

        // Reset while offering.
        press(1); press(0); press(0);
        push_enter = 1'b1; tick(); push_enter = 1'b0;
        tick(); tick(); tick(); tick();
        check("pre_rst_valid", 32'(valid), 32'd1);
        rst = 1'b0; tick(); rst = 1'b1;
        q.delete();
        check("rst_req_valid", 32'(valid), 32'd0);
        check("rst_req_amount", 32'(amount), 32'd0);
        check("rst_req_busy", 32'(busy), 32'd0);

        // Clear during conversion aborts; no offer appears afterwards.
        press(5); press(0);
        push_enter = 1'b1; tick(); push_enter = 1'b0;
        tick();
        check("abort_pre_busy", 32'(busy), 32'd1);
        clear();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_valid", 32'(valid), 32'd0);
        end

        // Randomized entries against the model.
        for (int t = 0; t < 40; t++) begin
            int n = $urandom_range(1, 4);
            int bad_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
            for (int i = 0; i < n; i++) begin
                int d = (i == bad_at) ? $urandom_range(10, 15)
                      : (i == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, 2)
                      : $urandom_range(0, 9);
                press(d);
            end
            if (merr) clear();
            else enter_and_finish($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
